// File: rtl/hawk_cmpdcmp_wr_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hawk_cmpdcmp_wr_engine: streams compressed/decompressed lines to the     |
// | internal AXI write channel, then writes the zsPage metadata line.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hawk_cmpdcmp_wr_engine #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 512,
  parameter int PTR_W      = 48,
  parameter int MD_W       = 400,
  parameter int PAGE_BYTES = 4096,
  parameter int CNT_W      = 7
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                trig_i,
  input  logic                comp_i,
  input  logic [ADDR_W-1:0]   start_addr_i,
  input  logic [CNT_W-1:0]    cline_cnt_i,
  input  logic [PTR_W-1:0]    iway_ptr_i,
  input  logic [PTR_W-1:0]    nxtway_ptr_i,
  input  logic [MD_W-1:0]     zspg_md_i,
  input  logic                src_valid_i,
  input  logic [DATA_W-1:0]   src_data_i,
  output logic                src_ready_o,
  output logic                wr_valid_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic [DATA_W/8-1:0] wr_strb_o,
  input  logic                wr_ready_i,
  output logic                busy_o,
  output logic                done_o
);

  localparam int STRB_W     = DATA_W / 8;
  localparam int BEAT_SHIFT = $clog2(STRB_W);
  localparam int PAGE_LINES = PAGE_BYTES / STRB_W;
  localparam int MD_BYTES   = (MD_W + 2 * PTR_W) / 8;
  localparam logic [STRB_W-1:0] MD_STRB = {STRB_W{1'b1}} >> (STRB_W - MD_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_XFER = 3'd1,
    ST_MD   = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic [CNT_W-1:0]    total_q, total_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic [CNT_W-1:0]    accepted_q, accepted_d;
  logic [PTR_W-1:0]    iway_q, iway_d;
  logic [PTR_W-1:0]    nxtway_q, nxtway_d;
  logic [MD_W-1:0]     md_q, md_d;
  logic                busy_q, busy_d;
  logic                wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [STRB_W-1:0]   wr_strb_q, wr_strb_d;

  logic [CNT_W-1:0]    trig_total;
  logic                src_ready;
  logic                pop;
  logic                accept;

  assign trig_total = comp_i ? cline_cnt_i : CNT_W'(PAGE_LINES);

  // The slot can take a new line when it is empty or being drained this cycle.
  assign src_ready = (state_q == ST_XFER) && (issued_q < total_q) &&
                     (!wr_valid_q || wr_ready_i);
  assign pop       = src_ready && src_valid_i;
  assign accept    = wr_valid_q && wr_ready_i;

  always_comb begin
    state_d      = state_q;
    start_addr_d = start_addr_q;
    total_d      = total_q;
    issued_d     = issued_q;
    accepted_d   = accepted_q;
    iway_d       = iway_q;
    nxtway_d     = nxtway_q;
    md_d         = md_q;
    busy_d       = busy_q;
    wr_valid_d   = wr_valid_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_strb_d    = wr_strb_q;

    unique case (state_q)
      ST_IDLE: begin
        if (trig_i) begin
          start_addr_d = start_addr_i;
          total_d      = trig_total;
          issued_d     = '0;
          accepted_d   = '0;
          iway_d       = iway_ptr_i;
          nxtway_d     = nxtway_ptr_i;
          md_d         = zspg_md_i;
          busy_d       = 1'b1;
          state_d      = (trig_total == '0) ? ST_MD : ST_XFER;
        end
      end
      ST_XFER: begin
        if (accept) begin
          wr_valid_d = 1'b0;
          accepted_d = accepted_q + CNT_W'(1);
          if ((accepted_q + CNT_W'(1)) == total_q) begin
            state_d = ST_MD;
          end
        end
        if (pop) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = start_addr_q + (ADDR_W'(issued_q) << BEAT_SHIFT);
          wr_data_d  = src_data_i;
          wr_strb_d  = '1;
          issued_d   = issued_q + CNT_W'(1);
        end
      end
      ST_MD: begin
        wr_valid_d = 1'b1;
        wr_addr_d  = ADDR_W'(iway_q);
        wr_data_d  = DATA_W'({md_q, nxtway_q, iway_q});
        wr_strb_d  = MD_STRB;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (accept) begin
          wr_valid_d = 1'b0;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      start_addr_q <= '0;
      total_q      <= '0;
      issued_q     <= '0;
      accepted_q   <= '0;
      iway_q       <= '0;
      nxtway_q     <= '0;
      md_q         <= '0;
      busy_q       <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_strb_q    <= '0;
    end else begin
      state_q      <= state_d;
      start_addr_q <= start_addr_d;
      total_q      <= total_d;
      issued_q     <= issued_d;
      accepted_q   <= accepted_d;
      iway_q       <= iway_d;
      nxtway_q     <= nxtway_d;
      md_q         <= md_d;
      busy_q       <= busy_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_strb_q    <= wr_strb_d;
    end
  end

  assign src_ready_o = src_ready;
  assign wr_valid_o  = wr_valid_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign wr_strb_o   = wr_strb_q;
  assign busy_o      = busy_q;
  assign done_o      = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_hawk_cmpdcmp_wr_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hawk_cmpdcmp_wr_engine: randomized bench with a write-list model.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_hawk_cmpdcmp_wr_engine;
  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 512;
  localparam int PTR_W      = 48;
  localparam int MD_W       = 400;
  localparam int PAGE_BYTES = 4096;
  localparam int CNT_W      = 7;
  localparam int STRB_W     = DATA_W / 8;
  localparam int PAGE_LINES = PAGE_BYTES / STRB_W;
  localparam int SH         = $clog2(STRB_W);

  logic              clk = 1'b0;
  logic              rst_ni = 1'b1;
  logic              trig_i = 1'b0;
  logic              comp_i = 1'b0;
  logic [ADDR_W-1:0] start_addr_i = '0;
  logic [CNT_W-1:0]  cline_cnt_i = '0;
  logic [PTR_W-1:0]  iway_ptr_i = '0;
  logic [PTR_W-1:0]  nxtway_ptr_i = '0;
  logic [MD_W-1:0]   zspg_md_i = '0;
  logic              src_valid_i = 1'b0;
  logic [DATA_W-1:0] src_data_i = '0;
  logic              src_ready_o;
  logic              wr_valid_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic [STRB_W-1:0] wr_strb_o;
  logic              wr_ready_i = 1'b0;
  logic              busy_o;
  logic              done_o;

  hawk_cmpdcmp_wr_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PTR_W(PTR_W), .MD_W(MD_W),
    .PAGE_BYTES(PAGE_BYTES), .CNT_W(CNT_W)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .trig_i(trig_i), .comp_i(comp_i),
    .start_addr_i(start_addr_i), .cline_cnt_i(cline_cnt_i),
    .iway_ptr_i(iway_ptr_i), .nxtway_ptr_i(nxtway_ptr_i), .zspg_md_i(zspg_md_i),
    .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_ready_o(src_ready_o),
    .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .wr_strb_o(wr_strb_o), .wr_ready_i(wr_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] src_lines[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [DATA_W-1:0] exp_data[$];
  logic [STRB_W-1:0] exp_strb[$];
  logic [ADDR_W-1:0] obs_addr[$];
  logic [DATA_W-1:0] obs_data[$];
  logic [STRB_W-1:0] obs_strb[$];
  int                obs_cyc[$];
  int  done_cnt, srdy_seen, pops, stable_err;
  bit  timed_out, busy_first, busy_after, idle_after;

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] l;
    for (int w = 0; w < DATA_W / 32; w++) l[w*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] a;
    a = {$urandom(), $urandom()};
    a[SH-1:0] = '0;
    return a;
  endfunction

  // Expected write list: data lines in source order, then the metadata line.
  function automatic void build_model(input bit comp, input logic [ADDR_W-1:0] sa, input int cnt,
                                      input logic [PTR_W-1:0] iw, input logic [PTR_W-1:0] nx,
                                      input logic [MD_W-1:0] md);
    int total;
    logic [DATA_W-1:0] d;
    logic [STRB_W-1:0] s;
    total = comp ? cnt : PAGE_LINES;
    exp_addr.delete(); exp_data.delete(); exp_strb.delete();
    for (int i = 0; i < total; i++) begin
      exp_addr.push_back(sa + ADDR_W'(i * STRB_W));
      exp_data.push_back(src_lines[i]);
      exp_strb.push_back('1);
    end
    d = '0;
    d[PTR_W-1:0] = iw;
    d[2*PTR_W-1:PTR_W] = nx;
    d[2*PTR_W+MD_W-1:2*PTR_W] = md;
    s = '0;
    for (int b = 0; b < (MD_W + 2 * PTR_W) / 8; b++) s[b] = 1'b1;
    exp_addr.push_back(ADDR_W'(iw));
    exp_data.push_back(d);
    exp_strb.push_back(s);
  endfunction

  // Drives one transaction and records every accepted write; abort_after>0 stops early.
  task automatic drive_txn(input bit comp, input logic [ADDR_W-1:0] sa, input int cnt,
                           input int rdy_pct, input int val_pct, input bit retrig,
                           input int abort_after);
    logic [PTR_W-1:0]  iw, nx;
    logic [MD_W-1:0]   md;
    logic [DATA_W-1:0] t;
    logic [ADDR_W-1:0] pa;
    logic [DATA_W-1:0] pd;
    logic [STRB_W-1:0] ps;
    bit prev_stall, got_done;
    int total, post;
    iw = PTR_W'({$urandom(), $urandom()});
    nx = PTR_W'({$urandom(), $urandom()});
    t  = rand_line();
    md = t[MD_W-1:0];
    total = comp ? cnt : PAGE_LINES;
    src_lines.delete();
    for (int i = 0; i < total; i++) src_lines.push_back(rand_line());
    build_model(comp, sa, cnt, iw, nx, md);
    obs_addr.delete(); obs_data.delete(); obs_strb.delete(); obs_cyc.delete();
    done_cnt = 0; srdy_seen = 0; pops = 0; stable_err = 0;
    timed_out = 0; busy_first = 0; busy_after = 1; idle_after = 0;
    prev_stall = 0; got_done = 0; post = 0;
    pa = '0; pd = '0; ps = '0;
    @(negedge clk);
    trig_i = 1'b1; comp_i = comp; start_addr_i = sa; cline_cnt_i = CNT_W'(cnt);
    iway_ptr_i = iw; nxtway_ptr_i = nx; zspg_md_i = md;
    wr_ready_i = 1'b0; src_valid_i = 1'b0;
    for (int cyc = 0; ; cyc++) begin
      @(negedge clk);
      if (cyc >= 4000) begin timed_out = 1; break; end
      trig_i       = retrig && !got_done;
      comp_i       = 1'($urandom());
      start_addr_i = rand_addr();
      cline_cnt_i  = CNT_W'($urandom());
      iway_ptr_i   = PTR_W'({$urandom(), $urandom()});
      nxtway_ptr_i = PTR_W'({$urandom(), $urandom()});
      if (rdy_pct < 0) wr_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
      else             wr_ready_i = ($urandom_range(99) < rdy_pct);
      src_valid_i = ($urandom_range(99) < val_pct);
      src_data_i  = (pops < src_lines.size()) ? src_lines[pops] : rand_line();
      #1;
      if (cyc == 0) busy_first = busy_o;
      if (got_done) begin
        post++;
        if (post == 1) busy_after = busy_o | done_o;
        else begin idle_after = !busy_o && !wr_valid_o; break; end
        continue;
      end
      if (done_o) begin done_cnt++; got_done = 1; end
      if (src_ready_o) srdy_seen++;
      if (prev_stall && (!wr_valid_o || wr_addr_o !== pa || wr_data_o !== pd || wr_strb_o !== ps))
        stable_err++;
      prev_stall = wr_valid_o && !wr_ready_i;
      pa = wr_addr_o; pd = wr_data_o; ps = wr_strb_o;
      if (wr_valid_o && wr_ready_i) begin
        obs_addr.push_back(wr_addr_o);
        obs_data.push_back(wr_data_o);
        obs_strb.push_back(wr_strb_o);
        obs_cyc.push_back(cyc);
      end
      if (src_ready_o && src_valid_i) pops++;
      if (abort_after > 0 && obs_addr.size() == abort_after) return;
    end
    trig_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({wr_valid_o, src_ready_o, busy_o, done_o} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 0000", {wr_valid_o, src_ready_o, busy_o, done_o});
    end
    n_cmp++;
    if (wr_addr_o !== '0 || wr_strb_o !== '0 || wr_data_o !== '0) begin
      n_err++; $display("FAIL reset_bus: got addr=%h strb=%h expected 0", wr_addr_o, wr_strb_o);
    end
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({wr_valid_o, src_ready_o, busy_o, done_o} !== 4'b0) begin
      n_err++; $display("FAIL reset_release: got %b expected 0000", {wr_valid_o, src_ready_o, busy_o, done_o});
    end
  endtask

  task automatic test_decompress();
    drive_txn(1'b0, 64'h1000, 0, 100, 100, 1'b0, 0);
    n_cmp++;
    if (timed_out || done_cnt != 1) begin
      n_err++; $display("FAIL dec_done: got done=%0d timeout=%0d expected done=1", done_cnt, timed_out);
    end
    n_cmp++;
    if (busy_first !== 1'b1 || busy_after !== 1'b0) begin
      n_err++; $display("FAIL dec_busy: got first=%0d after=%0d expected 1/0", busy_first, busy_after);
    end
    n_cmp++;
    if (obs_addr.size() != exp_addr.size()) begin
      n_err++; $display("FAIL dec_count: got %0d expected %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      if ({obs_addr[i], obs_strb[i], obs_data[i]} !== {exp_addr[i], exp_strb[i], exp_data[i]}) begin
        n_err++; $display("FAIL dec_beat%0d: got addr=%h strb=%h data=%h expected addr=%h strb=%h data=%h",
                          i, obs_addr[i], obs_strb[i], obs_data[i], exp_addr[i], exp_strb[i], exp_data[i]);
      end
    end
    if (obs_cyc.size() >= PAGE_LINES + 1) begin
      n_cmp++;
      if (obs_cyc[PAGE_LINES-1] - obs_cyc[0] != PAGE_LINES - 1) begin
        n_err++; $display("FAIL dec_rate: got span %0d expected %0d", obs_cyc[PAGE_LINES-1] - obs_cyc[0], PAGE_LINES - 1);
      end
      n_cmp++;
      if (obs_strb[PAGE_LINES] !== 64'h3FFF_FFFF_FFFF_FFFF) begin
        n_err++; $display("FAIL dec_md_strb: got %h expected 3fffffffffffffff", obs_strb[PAGE_LINES]);
      end
    end
  endtask

  task automatic test_compress_stall();
    drive_txn(1'b1, rand_addr(), 3, -1, 100, 1'b0, 0);
    n_cmp++;
    if (timed_out || done_cnt != 1 || stable_err != 0) begin
      n_err++; $display("FAIL stall_ctl: got done=%0d timeout=%0d unstable=%0d expected 1/0/0", done_cnt, timed_out, stable_err);
    end
    n_cmp++;
    if (obs_addr.size() != 4) begin
      n_err++; $display("FAIL stall_count: got %0d expected 4", obs_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      if ({obs_addr[i], obs_strb[i], obs_data[i]} !== {exp_addr[i], exp_strb[i], exp_data[i]}) begin
        n_err++; $display("FAIL stall_beat%0d: got addr=%h strb=%h data=%h expected addr=%h strb=%h data=%h",
                          i, obs_addr[i], obs_strb[i], obs_data[i], exp_addr[i], exp_strb[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_zero_lines();
    drive_txn(1'b1, rand_addr(), 0, 60, 100, 1'b0, 0);
    n_cmp++;
    if (timed_out || done_cnt != 1 || srdy_seen != 0) begin
      n_err++; $display("FAIL zero_ctl: got done=%0d timeout=%0d src_ready=%0d expected 1/0/0", done_cnt, timed_out, srdy_seen);
    end
    n_cmp++;
    if (obs_addr.size() != 1) begin
      n_err++; $display("FAIL zero_count: got %0d expected 1", obs_addr.size());
    end else begin
      n_cmp++;
      if ({obs_addr[0], obs_strb[0], obs_data[0]} !== {exp_addr[0], exp_strb[0], exp_data[0]}) begin
        n_err++; $display("FAIL zero_md: got addr=%h strb=%h expected addr=%h strb=%h",
                          obs_addr[0], obs_strb[0], exp_addr[0], exp_strb[0]);
      end
    end
  endtask

  task automatic test_retrigger();
    drive_txn(1'b1, rand_addr(), 5, 70, 70, 1'b1, 0);
    n_cmp++;
    if (timed_out || done_cnt != 1 || idle_after !== 1'b1 || busy_after !== 1'b0) begin
      n_err++; $display("FAIL retrig_ctl: got done=%0d timeout=%0d idle=%0d busy=%0d expected 1/0/1/0",
                        done_cnt, timed_out, idle_after, busy_after);
    end
    n_cmp++;
    if (obs_addr.size() != exp_addr.size()) begin
      n_err++; $display("FAIL retrig_count: got %0d expected %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      if ({obs_addr[i], obs_strb[i], obs_data[i]} !== {exp_addr[i], exp_strb[i], exp_data[i]}) begin
        n_err++; $display("FAIL retrig_beat%0d: got addr=%h strb=%h expected addr=%h strb=%h",
                          i, obs_addr[i], obs_strb[i], exp_addr[i], exp_strb[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [ADDR_W-1:0] sa2;
    drive_txn(1'b0, 64'h2000, 0, 100, 100, 1'b0, 10);
    n_cmp++;
    if (obs_addr.size() != 10 || done_cnt != 0) begin
      n_err++; $display("FAIL rmid_pre: got beats=%0d done=%0d expected 10/0", obs_addr.size(), done_cnt);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({wr_valid_o, src_ready_o, busy_o, done_o} !== 4'b0 || wr_addr_o !== '0 || wr_strb_o !== '0) begin
      n_err++; $display("FAIL rmid_async: got ctrl=%b addr=%h strb=%h expected 0",
                        {wr_valid_o, src_ready_o, busy_o, done_o}, wr_addr_o, wr_strb_o);
    end
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    sa2 = 64'h0000_0000_0040_0000;
    drive_txn(1'b0, sa2, 0, 80, 80, 1'b0, 0);
    n_cmp++;
    if (timed_out || done_cnt != 1 || obs_addr.size() != exp_addr.size()) begin
      n_err++; $display("FAIL rmid_restart: got done=%0d timeout=%0d beats=%0d expected 1/0/%0d",
                        done_cnt, timed_out, obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      if ({obs_addr[i], obs_strb[i], obs_data[i]} !== {exp_addr[i], exp_strb[i], exp_data[i]}) begin
        n_err++; $display("FAIL rmid_beat%0d: got addr=%h strb=%h expected addr=%h strb=%h",
                          i, obs_addr[i], obs_strb[i], exp_addr[i], exp_strb[i]);
      end
    end
  endtask

  task automatic test_wrap();
    drive_txn(1'b1, 64'hFFFF_FFFF_FFFF_FF80, 4, 100, 60, 1'b0, 0);
    n_cmp++;
    if (timed_out || done_cnt != 1 || obs_addr.size() != 5) begin
      n_err++; $display("FAIL wrap_ctl: got done=%0d timeout=%0d beats=%0d expected 1/0/5", done_cnt, timed_out, obs_addr.size());
    end
    if (obs_addr.size() >= 4) begin
      n_cmp++;
      if (obs_addr[2] !== 64'h0 || obs_addr[3] !== 64'h40) begin
        n_err++; $display("FAIL wrap_addr: got %h %h expected 0 40", obs_addr[2], obs_addr[3]);
      end
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      n_cmp++;
      if ({obs_addr[i], obs_strb[i], obs_data[i]} !== {exp_addr[i], exp_strb[i], exp_data[i]}) begin
        n_err++; $display("FAIL wrap_beat%0d: got addr=%h strb=%h expected addr=%h strb=%h",
                          i, obs_addr[i], obs_strb[i], exp_addr[i], exp_strb[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      drive_txn(1'($urandom()), rand_addr(), int'($urandom_range(20)),
                int'($urandom_range(100, 40)), int'($urandom_range(100, 40)), 1'b0, 0);
      n_cmp++;
      if (timed_out || done_cnt != 1 || stable_err != 0 || obs_addr.size() != exp_addr.size()) begin
        n_err++; $display("FAIL rand%0d_ctl: got done=%0d timeout=%0d unstable=%0d beats=%0d expected 1/0/0/%0d",
                          k, done_cnt, timed_out, stable_err, obs_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
        n_cmp++;
        if ({obs_addr[i], obs_strb[i], obs_data[i]} !== {exp_addr[i], exp_strb[i], exp_data[i]}) begin
          n_err++; $display("FAIL rand%0d_beat%0d: got addr=%h strb=%h expected addr=%h strb=%h",
                            k, i, obs_addr[i], obs_strb[i], exp_addr[i], exp_strb[i]);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decompress();
    test_compress_stall();
    test_zero_lines();
    test_retrigger();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
